// File: rtl/huffman_coder_pkg.sv
// Shared constants, field positions and the fixed prefix-code table for huffman_coder.
package huffman_coder_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned MAX_LEN  = 7;
  localparam int unsigned SYM_W    = 4;
  localparam int unsigned MAX_SYMS = 6;

  localparam int unsigned LEN_W    = 3;
  localparam int unsigned FILL_W   = 5;
  localparam int unsigned NSYM_W   = 3;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PACK_W   = 2 * WORD_W;
  localparam int unsigned SH_W     = 7;

  localparam int unsigned CMD_FLUSH  = 31;
  localparam int unsigned CMD_N_LO   = 28;
  localparam int unsigned CMD_SYM_LO = 0;
  localparam int unsigned CMD_SYM_W  = SYM_W * MAX_SYMS;

  localparam int unsigned STS_BUSY    = 31;
  localparam int unsigned STS_DROP    = 30;
  localparam int unsigned STS_FILL_LO = 16;
  localparam int unsigned STS_FILL_W  = 6;
  localparam int unsigned STS_CNT_LO  = 0;

  typedef struct packed {
    logic [MAX_LEN-1:0] code;
    logic [LEN_W-1:0]   len;
  } code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Right-aligned code and its length; symbols 8..15 share the 1111 escape prefix.
  function automatic code_t huff_lookup(input logic [SYM_W-1:0] sym);
    code_t c;
    c = '0;
    if (sym[3]) begin
      c.code = {4'b1111, sym[2:0]};
      c.len  = 3'd7;
    end else begin
      case (sym[2:1])
        2'd0:    begin c.code = {6'b000000, sym[0]}; c.len = 3'd2; end
        2'd1:    begin c.code = {6'b000010, sym[0]}; c.len = 3'd3; end
        2'd2:    begin c.code = {6'b000110, sym[0]}; c.len = 3'd4; end
        default: begin c.code = {6'b001110, sym[0]}; c.len = 3'd5; end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/huffman_code_rom.sv
// Combinational symbol -> (right-aligned code, length) map.
module huffman_code_rom
  import huffman_coder_pkg::*;
(
  input  logic [SYM_W-1:0]   sym,
  output logic [MAX_LEN-1:0] code_c,
  output logic [LEN_W-1:0]   len_c
);

  code_t entry;

  always_comb begin
    entry  = huff_lookup(sym);
    code_c = entry.code;
    len_c  = entry.len;
  end

endmodule

// File: rtl/huffman_coder.sv
// Avalon-MM Huffman encoder: batch sequencer, MSB-first word packer and status register.
// Optional HUFFMAN_CODER_STATS_EN adds the emitted-word counter and sticky drop flag.
module huffman_coder
  import huffman_coder_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              chipselect,
  input  logic              write,
  input  logic [WORD_W-1:0] writedata,
  input  logic              read,
  output logic [WORD_W-1:0] readdata,
  output logic [WORD_W-1:0] encoded_out,
  output logic              enable_out
);

  state_t                state_q, state_d;
  logic [CMD_SYM_W-1:0]  syms_q;
  logic [NSYM_W-1:0]     left_q;
  logic                  flush_q;
  logic [WORD_W-1:0]     acc_q;
  logic [FILL_W-1:0]     fill_q;

  logic                  wr_c, rd_c, accept_c;
  logic                  load_c, enc_c, flush_c, busy_c;
  logic [NSYM_W-1:0]     n_raw_c, n_c;
  logic [MAX_LEN-1:0]    rom_code_c;
  logic [LEN_W-1:0]      rom_len_c;
  logic [FILL_W:0]       sum_c;
  logic                  wrap_c, emit_c;
  logic [SH_W-1:0]       shamt_c;
  logic [PACK_W-1:0]     pack_c;
  logic [WORD_W-1:0]     emit_word_c, status_c;
  logic                  unused_bits;

  assign unused_bits = ^writedata[27:24];

  assign wr_c     = chipselect & write;
  assign rd_c     = chipselect & read;
  assign accept_c = wr_c & ~busy_c;
  assign n_raw_c  = writedata[CMD_N_LO +: NSYM_W];
  assign n_c      = (n_raw_c == 3'd7) ? NSYM_W'(MAX_SYMS) : n_raw_c;

  huffman_code_rom u_rom (
    .sym    (syms_q[SYM_W-1:0]),
    .code_c (rom_code_c),
    .len_c  (rom_len_c)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (n_c != '0)                 state_d = ST_ENC;
          else if (writedata[CMD_FLUSH]) state_d = ST_FLUSH;
        end
      end
      ST_ENC:   if (left_q == 3'd1) state_d = flush_q ? ST_FLUSH : ST_IDLE;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_c  = 1'b0;
    enc_c   = 1'b0;
    flush_c = 1'b0;
    busy_c  = 1'b1;
    case (state_q)
      ST_IDLE:  begin busy_c = 1'b0; load_c = accept_c; end
      ST_ENC:   enc_c   = 1'b1;
      ST_FLUSH: flush_c = 1'b1;
      default:  busy_c  = 1'b0;
    endcase
  end

  // Place the code directly below the occupied bits in a double-width window.
  always_comb begin
    sum_c       = (FILL_W + 1)'(fill_q) + (FILL_W + 1)'(rom_len_c);
    wrap_c      = sum_c[FILL_W];
    shamt_c     = SH_W'(PACK_W) - SH_W'(sum_c);
    pack_c      = {acc_q, {WORD_W{1'b0}}} | (PACK_W'(rom_code_c) << shamt_c);
    emit_c      = (enc_c & wrap_c) | (flush_c & (fill_q != '0));
    emit_word_c = flush_c ? acc_q : pack_c[PACK_W-1:WORD_W];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      syms_q      <= '0;
      left_q      <= '0;
      flush_q     <= 1'b0;
      acc_q       <= '0;
      fill_q      <= '0;
      encoded_out <= '0;
      enable_out  <= 1'b0;
    end else begin
      enable_out <= emit_c;
      if (emit_c) encoded_out <= emit_word_c;
      if (load_c) begin
        syms_q  <= writedata[CMD_SYM_LO +: CMD_SYM_W];
        left_q  <= n_c;
        flush_q <= writedata[CMD_FLUSH];
      end
      if (enc_c) begin
        syms_q <= syms_q >> SYM_W;
        left_q <= left_q - 3'd1;
        acc_q  <= wrap_c ? pack_c[WORD_W-1:0] : pack_c[PACK_W-1:WORD_W];
        fill_q <= sum_c[FILL_W-1:0];
      end else if (flush_c) begin
        acc_q  <= '0;
        fill_q <= '0;
      end
    end
  end

`ifdef HUFFMAN_CODER_STATS_EN
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q;

  // A drop in the same cycle as a served read keeps the flag set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (emit_c) cnt_q <= cnt_q + 16'd1;
      drop_q <= (wr_c & busy_c) | (drop_q & ~rd_c);
    end
  end
`endif

  always_comb begin
    status_c = '0;
    status_c[STS_BUSY] = busy_c;
    status_c[STS_FILL_LO +: STS_FILL_W] = STS_FILL_W'(fill_q);
`ifdef HUFFMAN_CODER_STATS_EN
    status_c[STS_DROP] = drop_q;
    status_c[STS_CNT_LO +: CNT_W] = cnt_q;
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   readdata <= '0;
    else if (rd_c) readdata <= status_c;
  end

endmodule

// File: tb/tb_huffman_coder.sv
// Self-checking bench for huffman_coder: directed cases plus random batches against a bit-queue model.
module tb_huffman_coder;

`ifdef HUFFMAN_CODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn, chipselect, write, read;
  logic [31:0] writedata, readdata, encoded_out;
  logic        enable_out;

  huffman_coder dut (
    .clock       (clock),
    .resetn      (resetn),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .encoded_out (encoded_out),
    .enable_out  (enable_out)
  );

  always #5 clock = ~clock;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pulses   = 0;
  logic [31:0] last_pulse = '0;

  int unsigned code_tab [16] = '{0, 1, 4, 5, 12, 13, 28, 29,
                                 120, 121, 122, 123, 124, 125, 126, 127};
  int unsigned len_tab  [16] = '{2, 2, 3, 3, 4, 4, 5, 5, 7, 7, 7, 7, 7, 7, 7, 7};

  bit          bits_q [$];
  logic [31:0] exp_q  [$];
  int unsigned words = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic take_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w = {w[30:0], bits_q.pop_front()};
    exp_q.push_back(w);
    words++;
  endtask

  // Append every code as a bit string; each 32 bits make one word.
  task automatic model_batch(input logic [31:0] cmd);
    int n;
    int unsigned s, c, l;
    n = int'(cmd[30:28]);
    if (n == 7) n = 6;
    for (int k = 0; k < n; k++) begin
      s = (cmd >> (4 * k)) & 32'hF;
      c = code_tab[s];
      l = len_tab[s];
      for (int b = int'(l) - 1; b >= 0; b--) begin
        bits_q.push_back(c[b]);
        if (bits_q.size() == 32) take_word();
      end
    end
    if (cmd[31] && bits_q.size() != 0) begin
      while (bits_q.size() < 32) bits_q.push_back(1'b0);
      take_word();
    end
  endtask

  task automatic wr(input logic [31:0] d, input bit apply);
    chipselect = 1'b1;
    write      = 1'b1;
    writedata  = d;
    if (apply) model_batch(d);
    @(negedge clock);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic rd(output logic [31:0] st);
    chipselect = 1'b1;
    read       = 1'b1;
    @(negedge clock);
    chipselect = 1'b0;
    read       = 1'b0;
    st = readdata;
  endtask

  task automatic wait_idle(output logic [31:0] st);
    for (int i = 0; i < 40; i++) begin
      rd(st);
      if (!st[31]) break;
    end
    check("idle", 32'(st[31]), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic [31:0] st);
    check({tag, "_fill"}, 32'(st[21:16]), 32'(bits_q.size()));
    check({tag, "_cnt"}, 32'(st[15:0]), STATS ? (words & 32'hFFFF) : 32'd0);
  endtask

  always @(negedge clock) begin
    if (resetn === 1'b1 && enable_out === 1'b1) begin
      pulses++;
      last_pulse = encoded_out;
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("pulse_word", encoded_out, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] st;
    int unsigned p0;
    resetn = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0; writedata = '0;
    repeat (3) @(negedge clock);
    check("rst_encoded", encoded_out, 32'd0);
    check("rst_enable", 32'(enable_out), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    rd(st);
    check("rst_status", st, 32'd0);

    p0 = pulses;
    wr(32'h9000_000F, 1'b1);
    wait_idle(st);
    check("sym15_word", last_pulse, 32'hFE00_0000);
    check("sym15_pulses", pulses - p0, 32'd1);
    check_status("sym15", st);

    p0 = pulses;
    wr(32'h6011_1111, 1'b1); wait_idle(st);
    wr(32'h6011_1111, 1'b1); wait_idle(st);
    wr(32'h4000_1111, 1'b1); wait_idle(st);
    check("ones_word", last_pulse, 32'h5555_5555);
    check("ones_pulses", pulses - p0, 32'd1);
    check_status("ones", st);

    wr(32'h500F_FFFF, 1'b1); wait_idle(st);
    check("carry_word", last_pulse, 32'hFFFF_FFFF);
    check("carry_fill", 32'(st[21:16]), 32'd3);
    wr(32'h8000_0000, 1'b1); wait_idle(st);
    check("carry_flush", last_pulse, 32'hE000_0000);
    check_status("carry", st);

    wr(32'h6000_0000, 1'b1);
    wr(32'h1000_0005, 1'b0);
    rd(st);
    check("drop_busy", 32'(st[31]), 32'd1);
    check("drop_set", 32'(st[30]), 32'(STATS));
    rd(st);
    check("drop_clear", 32'(st[30]), 32'd0);
    wait_idle(st);
    check_status("drop", st);

    p0 = pulses;
    wr(32'h6077_7777, 1'b1);
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    bits_q.delete();
    exp_q.delete();
    words = 0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    rd(st);
    check("midrst_status", st, 32'd0);
    check("midrst_pulses", pulses - p0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      wr($urandom, 1'b1);
      wait_idle(st);
      check_status("rand", st);
    end
    repeat (3) @(negedge clock);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
